// File: rtl/sort_seq.sv
// sort_seq: odd-even transposition sorter, one compare-exchange phase per clock.
// Exits early once two consecutive phases make no swap; start/busy/done handshake.
module sort_seq #(
  parameter int N  = 4,
  parameter int W  = 4,
  parameter int PW = $clog2(N+1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           desc,
  input  logic [N*W-1:0] din,
  output logic           busy,
  output logic           done,
  output logic [N*W-1:0] dout,
  output logic [PW-1:0]  passes
);

  typedef enum logic [1:0] {S_IDLE, S_SORT, S_DONE} state_t;

  state_t         state, state_nxt;
  logic [N*W-1:0] v, v_nxt;
  logic [PW-1:0]  p;
  logic           desc_q;
  logic           prev_noswap;
  logic           noswap;
  logic           last_phase;
  logic [W-1:0]   a, b;

  // Even phases pair (0,1),(2,3)...; odd phases pair (1,2),(3,4)...
  // Pairs within one phase are disjoint, so every compare reads the pre-phase vector.
  always_comb begin
    v_nxt  = v;
    noswap = 1'b1;
    a      = '0;
    b      = '0;
    for (int k = 0; k < N-1; k++) begin
      a = v[k*W +: W];
      b = v[(k+1)*W +: W];
      if (((k % 2) == 1) == p[0] && (desc_q ? (b > a) : (b < a))) begin
        v_nxt[k*W +: W]     = b;
        v_nxt[(k+1)*W +: W] = a;
        noswap              = 1'b0;
      end
    end
  end

  assign last_phase = (p == PW'(N-1)) || ((p != '0) && noswap && prev_noswap);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_SORT;
      end
      S_SORT: begin
        busy = 1'b1;
        if (last_phase) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = start ? S_SORT : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v           <= '0;
      p           <= '0;
      desc_q      <= 1'b0;
      prev_noswap <= 1'b0;
      dout        <= '0;
      passes      <= '0;
    end else if (state == S_SORT) begin
      v <= v_nxt;
      if (last_phase) begin
        dout   <= v_nxt;
        passes <= p + PW'(1);
      end else begin
        p           <= p + PW'(1);
        prev_noswap <= noswap;
      end
    end else if (start) begin
      v           <= din;
      desc_q      <= desc;
      p           <= '0;
      prev_noswap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sort_seq.sv
// Directed bench for sort_seq: N=4/W=4 handshake and result vectors, plus
// W=8 instances for N in {2,3,5,7,8} against an insertion-sort reference.
module tb_sort_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, desc4;
  logic [15:0] din4;
  logic        busy4, done4;
  logic [15:0] dout4;
  logic [2:0]  passes4;

  logic        rstart [5];
  logic        rdesc  [5];
  logic [63:0] rdin   [5];
  logic        rbusy  [5];
  logic        rdone  [5];
  logic [63:0] rdout  [5];
  logic [3:0]  rpasses[5];

  int n_chk  = 0;
  int n_pass = 0;
  bit seen_m;

  always #5 clk = ~clk;

  sort_seq #(.N(4), .W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .desc(desc4), .din(din4),
    .busy(busy4), .done(done4), .dout(dout4), .passes(passes4)
  );

  for (genvar g = 0; g < 5; g++) begin : gen_r
    localparam int NN  = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 5 : (g == 3) ? 7 : 8;
    localparam int PWG = $clog2(NN+1);
    logic [NN*8-1:0] d_o;
    logic [PWG-1:0]  p_o;
    sort_seq #(.N(NN), .W(8)) u_dut (
      .clk(clk), .rst(rst), .start(rstart[g]), .desc(rdesc[g]), .din(rdin[g][NN*8-1:0]),
      .busy(rbusy[g]), .done(rdone[g]), .dout(d_o), .passes(p_o)
    );
    assign rdout[g]   = 64'(d_o);
    assign rpasses[g] = 4'(p_o);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] ref_sort(input logic [63:0] d, input int n, input logic ds);
    logic [7:0]  e[8];
    logic [7:0]  key;
    logic [63:0] r;
    int j;
    for (int k = 0; k < 8; k++) e[k] = (k < n) ? d[8*k +: 8] : 8'd0;
    for (int i = 1; i < n; i++) begin
      key = e[i];
      j = i - 1;
      while (j >= 0 && (ds ? (e[j] < key) : (e[j] > key))) begin
        e[j+1] = e[j];
        j--;
      end
      e[j+1] = key;
    end
    r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = e[k];
    return r;
  endfunction

  // Caller sits just after a falling edge; returns at the falling edge where done is high.
  task automatic sort4(input logic [15:0] d, input logic ds, input logic [15:0] exp_d,
                       input int exp_p, input bit inj, input string tag);
    int nb;
    bit seen;
    nb = 0;
    seen = 0;
    din4 = d; desc4 = ds; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (done4) seen = 1;
      else begin
        if (busy4) nb++;
        if (inj && nb == 2) begin start4 = 1'b1; din4 = 16'h0000; end
        else start4 = 1'b0;
        @(negedge clk);
      end
    end
    start4 = 1'b0;
    chk({tag, "_done"},   64'(seen),    64'd1);
    chk({tag, "_dout"},   64'(dout4),   64'(exp_d));
    chk({tag, "_passes"}, 64'(passes4), 64'(exp_p));
    chk({tag, "_busy"},   64'(nb),      64'(exp_p));
  endtask

  task automatic run_gen(input int idx, input int n, input logic [63:0] d, input logic ds,
                         input logic [63:0] exp_d, input string tag);
    bit seen;
    seen = 0;
    rdin[idx] = d; rdesc[idx] = ds; rstart[idx] = 1'b1;
    @(negedge clk);
    rstart[idx] = 1'b0;
    for (int i = 0; i < n + 4 && !seen; i++) begin
      if (rdone[idx]) seen = 1;
      else @(negedge clk);
    end
    chk({tag, "_done"}, 64'(seen), 64'd1);
    chk({tag, "_dout"}, rdout[idx], exp_d);
    chk({tag, "_passes_range"}, 64'(rpasses[idx] >= 4'd2 && int'(rpasses[idx]) <= n), 64'd1);
    @(negedge clk);
  endtask

  task automatic run_random();
    int idx, n;
    logic [63:0] rd;
    logic ds;
    for (int s = 0; s < 4; s++) begin
      idx = (s < 2) ? s : s + 1;
      n   = (idx == 0) ? 2 : (idx == 1) ? 3 : (idx == 3) ? 7 : 8;
      for (int t = 0; t < 3; t++) begin
        rd = '0;
        for (int k = 0; k < n; k++) rd[8*k +: 8] = 8'($urandom_range(0, 20));
        ds = 1'($urandom_range(0, 1));
        run_gen(idx, n, rd, ds, ref_sort(rd, n, ds), $sformatf("rnd_n%0d_%0d", n, t));
      end
    end
  endtask

  initial begin
    rst = 1'b1; start4 = 1'b0; desc4 = 1'b0; din4 = '0;
    for (int i = 0; i < 5; i++) begin
      rstart[i] = 1'b0; rdesc[i] = 1'b0; rdin[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_busy",   64'(busy4),   64'd0);
    chk("rst_done",   64'(done4),   64'd0);
    chk("rst_dout",   64'(dout4),   64'd0);
    chk("rst_passes", 64'(passes4), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    sort4(16'h1234, 1'b0, 16'h4321, 4, 1'b0, "reverse");
    @(negedge clk);
    chk("reverse_done_1cyc", 64'(done4), 64'd0);
    sort4(16'h4312, 1'b0, 16'h4321, 3, 1'b0, "early3");
    @(negedge clk);
    sort4(16'h4321, 1'b0, 16'h4321, 2, 1'b0, "sorted");
    @(negedge clk);
    sort4(16'h4321, 1'b1, 16'h1234, 4, 1'b0, "desc");
    @(negedge clk);
    sort4(16'h5555, 1'b0, 16'h5555, 2, 1'b0, "dups");
    @(negedge clk);
    sort4(16'h1234, 1'b0, 16'h4321, 4, 1'b1, "ignore_start");
    @(negedge clk);

    // Back-to-back: second start is asserted while the first sort sits in DONE.
    sort4(16'h2143, 1'b0, 16'h4321, 4, 1'b0, "b2b_first");
    sort4(16'h8765, 1'b0, 16'h8765, 2, 1'b0, "b2b_second");
    @(negedge clk);
    chk("b2b_idle_after", 64'(busy4), 64'd0);

    // Asynchronous reset between edges while phase 1 is pending.
    din4 = 16'h1234; desc4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy",   64'(busy4),   64'd0);
    chk("midrst_done",   64'(done4),   64'd0);
    chk("midrst_dout",   64'(dout4),   64'd0);
    chk("midrst_passes", 64'(passes4), 64'd0);
    #1 rst = 1'b0;
    seen_m = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) seen_m = 1;
    end
    chk("midrst_no_done", 64'(seen_m), 64'd0);
    chk("midrst_dout_hold", 64'(dout4), 64'd0);
    sort4(16'h1234, 1'b0, 16'h4321, 4, 1'b0, "after_rst");
    @(negedge clk);

    run_gen(2, 5, 64'h0000_0011_C800_C809, 1'b0, 64'h0000_00C8_C811_0900, "n5_dir");
    run_random();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
